// File: rtl/audio_i2s_tx.sv
// I2S transmitter with an MCLK derived from a fractional accumulator. SCLK is MCLK/4,
// a frame is 64 SCLKs, and one sample pair is held in a single-entry holding register.
module audio_i2s_tx #(
  parameter int SAMPLE_WIDTH  = 16,
  parameter int ACCUM_INC     = 245760,
  parameter int ACCUM_MOD     = 742500,
  parameter int ACCUM_WIDTH   = 22,
  parameter bit UNDERRUN_ZERO = 1'b1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic signed [SAMPLE_WIDTH-1:0] sample_left,
  input  logic signed [SAMPLE_WIDTH-1:0] sample_right,
  input  logic                           sample_valid,
  output logic                           sample_ready,
  output logic                           audio_mclk,
  output logic                           audio_lrck,
  output logic                           audio_dac,
  output logic [15:0]                    underrun_count
);

  localparam logic [ACCUM_WIDTH-1:0] INC = ACCUM_WIDTH'(ACCUM_INC);
  localparam logic [ACCUM_WIDTH-1:0] MOD = ACCUM_WIDTH'(ACCUM_MOD);

  logic [ACCUM_WIDTH-1:0]         acc;
  logic [1:0]                     div;
  logic [4:0]                     bit_cnt;
  logic [31:0]                    shift;
  logic signed [SAMPLE_WIDTH-1:0] left_frm, right_frm;
  logic signed [SAMPLE_WIDTH-1:0] left_hold, right_hold;
  logic                           hold_full;

  logic                           wrap, mclk_rise, sclk_fall, slot_end, frame_start, xfer;
  logic signed [SAMPLE_WIDTH-1:0] left_nxt, right_nxt;

  // Sample left-justified in a 32-bit slot, low bits zero.
  function automatic logic [31:0] to_slot(input logic signed [SAMPLE_WIDTH-1:0] s);
    logic [31:0] r;
    r = '0;
    r[31 -: SAMPLE_WIDTH] = s;
    return r;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  assign wrap         = (acc >= MOD);
  assign mclk_rise    = wrap && !audio_mclk;
  assign sclk_fall    = mclk_rise && (div == 2'd3);
  assign slot_end     = sclk_fall && (bit_cnt == 5'd31);
  assign frame_start  = slot_end && audio_lrck;
  assign xfer         = sample_valid && !hold_full;
  assign sample_ready = !hold_full;

  // Frame registers as seen by the left slot loaded in the same cycle as frame start.
  always_comb begin
    left_nxt  = left_frm;
    right_nxt = right_frm;
    if (frame_start) begin
      if (hold_full) begin
        left_nxt  = left_hold;
        right_nxt = right_hold;
      end else if (UNDERRUN_ZERO) begin
        left_nxt  = '0;
        right_nxt = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc            <= '0;
      div            <= '0;
      bit_cnt        <= '0;
      shift          <= '0;
      left_frm       <= '0;
      right_frm      <= '0;
      left_hold      <= '0;
      right_hold     <= '0;
      hold_full      <= 1'b0;
      audio_mclk     <= 1'b0;
      audio_lrck     <= 1'b1;
      audio_dac      <= 1'b0;
      underrun_count <= '0;
    end else begin
      if (wrap) begin
        acc        <= acc - MOD + INC;
        audio_mclk <= !audio_mclk;
      end else begin
        acc <= acc + INC;
      end
      if (mclk_rise) div <= div + 2'd1;

      if (sclk_fall) begin
        audio_dac <= shift[31];
        bit_cnt   <= bit_cnt + 5'd1;
        if (slot_end) begin
          audio_lrck <= !audio_lrck;
          shift      <= audio_lrck ? to_slot(left_nxt) : to_slot(right_frm);
        end else begin
          shift <= {shift[30:0], 1'b0};
        end
      end

      left_frm  <= left_nxt;
      right_frm <= right_nxt;
      if (frame_start && !hold_full) underrun_count <= sat_inc(underrun_count);

      // Frame start sees the pre-transfer holding state; a same-cycle push still lands.
      if (xfer) begin
        left_hold  <= sample_left;
        right_hold <= sample_right;
        hold_full  <= 1'b1;
      end else if (frame_start) begin
        hold_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Directed bench for audio_i2s_tx with ACCUM_INC = ACCUM_MOD = 1 (SCLK falls every 8 clocks);
// a second instance with UNDERRUN_ZERO = 0 shares all inputs.
module tb_audio_i2s_tx;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic signed [15:0] sample_left  = '0;
  logic signed [15:0] sample_right = '0;
  logic               sample_valid = 1'b0;
  logic               ready_a, mclk_a, lrck_a, dac_a;
  logic               ready_b, mclk_b, lrck_b, dac_b;
  logic [15:0]        count_a, count_b;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] wa, wb;

  always #5 clock = !clock;

  audio_i2s_tx #(.SAMPLE_WIDTH(16), .ACCUM_INC(1), .ACCUM_MOD(1), .ACCUM_WIDTH(4),
                 .UNDERRUN_ZERO(1'b1)) dut_a (
    .clock(clock), .reset(reset), .sample_left(sample_left), .sample_right(sample_right),
    .sample_valid(sample_valid), .sample_ready(ready_a), .audio_mclk(mclk_a),
    .audio_lrck(lrck_a), .audio_dac(dac_a), .underrun_count(count_a));

  audio_i2s_tx #(.SAMPLE_WIDTH(16), .ACCUM_INC(1), .ACCUM_MOD(1), .ACCUM_WIDTH(4),
                 .UNDERRUN_ZERO(1'b0)) dut_b (
    .clock(clock), .reset(reset), .sample_left(sample_left), .sample_right(sample_right),
    .sample_valid(sample_valid), .sample_ready(ready_b), .audio_mclk(mclk_b),
    .audio_lrck(lrck_b), .audio_dac(dac_b), .underrun_count(count_b));

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Shift in n serial bits, one per SCLK falling event.
  task automatic get_bits(input int n, output logic [31:0] a, output logic [31:0] b);
    a = '0;
    b = '0;
    for (int i = 0; i < n; i++) begin
      step(8);
      a = {a[30:0], dac_a};
      b = {b[30:0], dac_b};
    end
  endtask

  initial begin
    step(2);
    chk("rst_mclk", mclk_a, 0);
    chk("rst_lrck", lrck_a, 1);
    chk("rst_dac", dac_a, 0);
    chk("rst_count", count_a, 0);
    chk("rst_ready", ready_a, 1);
    reset = 1'b0;

    // edge 1: accumulator only reaches MOD
    step(1);
    chk("mclk_e1", mclk_a, 0);
    sample_left  = 16'hA5C3;
    sample_right = 16'h8001;
    sample_valid = 1'b1;
    step(1);
    chk("mclk_e2", mclk_a, 1);
    chk("ready_after_push", ready_a, 0);
    sample_valid = 1'b0;
    step(1);
    chk("mclk_e3", mclk_a, 0);

    // first frame start on the 32nd SCLK fall = edge 256
    step(252);
    chk("lrck_e255", lrck_a, 1);
    step(1);
    chk("lrck_e256", lrck_a, 0);
    chk("ready_frame1", ready_a, 1);
    chk("count_frame1", count_a, 0);
    get_bits(32, wa, wb);
    chk("left_a5c3", wa, 32'hA5C3_0000);
    chk("lrck_right1", lrck_a, 1);
    get_bits(32, wa, wb);
    chk("right_8001", wa, 32'h8001_0000);
    chk("right_8001_b", wb, 32'h8001_0000);

    // frame 2 (edge 768): underrun
    chk("lrck_frame2", lrck_a, 0);
    chk("count_frame2", count_a, 1);
    get_bits(32, wa, wb);
    chk("uz_left_zero", wa, 0);
    chk("rep_left_b", wb, 32'hA5C3_0000);
    get_bits(31, wa, wb);
    chk("uz_right_zero", wa, 0);
    chk("rep_right_b", wb, 32'h4000_8000);

    // push lands on the frame-3 start edge (1280) with holding empty
    step(7);
    chk("ready_pre_coinc", ready_a, 1);
    sample_left  = 16'h7FFF;
    sample_right = 16'h0001;
    sample_valid = 1'b1;
    step(1);
    sample_valid = 1'b0;
    chk("lrck_frame3", lrck_a, 0);
    chk("count_coinc", count_a, 2);
    chk("count_coinc_b", count_b, 2);
    chk("ready_coinc", ready_a, 0);
    get_bits(32, wa, wb);
    chk("f3_left_zero", wa, 0);
    chk("f3_left_b", wb, 32'hA5C3_0000);
    chk("ready_hold_f3", ready_a, 0);
    get_bits(32, wa, wb);
    chk("f3_right_b", wb, 32'h8001_0000);

    // frame 4 (edge 1792): pushed pair consumed
    chk("count_frame4", count_a, 2);
    chk("ready_frame4", ready_a, 1);
    get_bits(32, wa, wb);
    chk("f4_left", wa, 32'h7FFF_0000);
    chk("f4_left_b", wb, 32'h7FFF_0000);
    get_bits(32, wa, wb);
    chk("f4_right", wa, 32'h0001_0000);
    chk("count_frame5", count_a, 3);

    // fill holding, then reset at bit_cnt 17 of the right slot (edge 2700)
    sample_left  = 16'h1234;
    sample_right = 16'h5678;
    sample_valid = 1'b1;
    step(1);
    sample_valid = 1'b0;
    chk("ready_full", ready_a, 0);
    step(394);
    chk("lrck_pre_reset", lrck_a, 1);
    reset = 1'b1;
    step(1);
    chk("mid_rst_mclk", mclk_a, 0);
    chk("mid_rst_lrck", lrck_a, 1);
    chk("mid_rst_dac", dac_a, 0);
    chk("mid_rst_count", count_a, 0);
    chk("mid_rst_ready", ready_a, 1);
    step(1);
    reset = 1'b0;

    // held pair was discarded: first frame after release underruns
    step(255);
    chk("post_lrck_e255", lrck_a, 1);
    step(1);
    chk("post_lrck_e256", lrck_a, 0);
    chk("post_count", count_a, 1);
    chk("post_count_b", count_b, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
